dmem_lsu_ctrl: RTL

- Load/store sequencer between the pipeline MEM stage and the 64 KiB data memory: asynchronous read, synchronous byte-enabled write, 16-bit byte address.
- Accepts one byte, half or word request at a time over a valid/ready handshake.
- Generates the word address, shifted write data and byte enables.
- Splits misaligned accesses into two sequential word accesses, then returns sign- or zero-extended load data.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/dmem_lsu_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store controller.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lsu_pkg;

  // Access size encoding as presented by the MEM stage; 2'b11 is illegal.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } state_e;

  // Right-aligned byte mask covering one access of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    size_mask = 4'h1;
      SZ_H:    size_mask = 4'h3;
      SZ_W:    size_mask = 4'hF;
      default: size_mask = 4'h0;
    endcase
  endfunction

  function automatic logic size_legal(input logic [1:0] size);
    size_legal = (size != 2'b11);
  endfunction

  // An access is split when its bytes straddle a word boundary.
  function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
    case (size_e'(size))
      SZ_H:    needs_split = (off == 2'd3);
      SZ_W:    needs_split = (off != 2'd0);
      default: needs_split = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store data/byte-enable alignment, load merge/extension and split detection.
// Latency: purely combinational.
// Backpressure: none; the parent FSM sequences all use of these results.
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [31:0] o_st_lo,
  output logic [31:0] o_st_hi,
  output logic [3:0]  o_wren_lo,
  output logic [3:0]  o_wren_hi,
  output logic [31:0] o_ld_data,
  output logic        o_split
);

  logic [63:0] st_shift;
  logic [7:0]  mask8;
  logic [31:0] ld_word;

  // Store data and mask are spread over two consecutive words; the low word
  // goes out in the first access and the high word in the second.
  assign st_shift  = {32'h0, i_wdata} << {i_off, 3'b000};
  assign mask8     = {4'h0, size_mask(i_size)} << i_off;
  assign o_st_lo   = st_shift[31:0];
  assign o_st_hi   = st_shift[63:32];
  assign o_wren_lo = mask8[3:0];
  assign o_wren_hi = mask8[7:4];
  assign o_split   = needs_split(i_size, i_off);

  // Load bytes are right-aligned out of the two fetched words.
  assign ld_word = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  // Truncate to the access size, then sign- or zero-extend.
  always_comb begin
    o_ld_data = ld_word;
    case (size_e'(i_size))
      SZ_B:    o_ld_data = i_unsigned ? {24'h0, ld_word[7:0]}
                                      : {{24{ld_word[7]}}, ld_word[7:0]};
      SZ_H:    o_ld_data = i_unsigned ? {16'h0, ld_word[15:0]}
                                      : {{16{ld_word[15]}}, ld_word[15:0]};
      default: o_ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a byte-enabled data memory.
// Latency: accept at edge T -> o_rsp_valid in cycle T+2 aligned, T+3 split, T+1 rejected.
// Backpressure: o_req_ready only in IDLE; requester holds its request while busy.
module dmem_lsu_ctrl import lsu_pkg::*; #(
  parameter bit MISALIGN_EN = 1'b1,
  parameter int ADDR_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [3:0]        o_mem_wren,
  input  logic [31:0]       i_mem_q
);

  localparam logic [ADDR_W-3:0] WA_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, lo_q, hi_q, rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_cur;
  logic [31:0]       mem_data_q, mem_data_cur;
  logic [3:0]        wren_cur;
  logic              accept, req_bad;
  logic [ADDR_W-3:0] wa0, wa1;
  logic [31:0]       st_lo, st_hi, ld_data, ld_lo, ld_hi;
  logic [3:0]        wren_lo, wren_hi;
  logic              split;

  // Second word wraps modulo the word-address space.
  assign wa0 = addr_q[ADDR_W-1:2];
  assign wa1 = wa0 + WA_ONE;

  // The word being read this cycle comes straight off the async memory port.
  assign ld_lo = (state_q == ACC0) ? i_mem_q : lo_q;
  assign ld_hi = (state_q == ACC1) ? i_mem_q : hi_q;

  lsu_align u_align (
    .i_size     (size_q),
    .i_off      (addr_q[1:0]),
    .i_unsigned (uns_q),
    .i_wdata    (wdata_q),
    .i_lo       (ld_lo),
    .i_hi       (ld_hi),
    .o_st_lo    (st_lo),
    .o_st_hi    (st_hi),
    .o_wren_lo  (wren_lo),
    .o_wren_hi  (wren_hi),
    .o_ld_data  (ld_data),
    .o_split    (split)
  );

  // Next-state, memory drive and response-data selection.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    o_req_ready  = 1'b0;
    accept       = 1'b0;
    mem_addr_cur = mem_addr_q;
    mem_data_cur = mem_data_q;
    wren_cur     = 4'h0;
    req_bad      = !size_legal(i_req_size) ||
                   (!MISALIGN_EN && needs_split(i_req_size, i_req_addr[1:0]));
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          accept  = 1'b1;
          rdata_d = 32'h0;
          state_d = req_bad ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_addr_cur = {wa0, 2'b00};
        mem_data_cur = st_lo;
        wren_cur     = we_q ? wren_lo : 4'h0;
        if (split) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? 32'h0 : ld_data;
        end
      end
      ACC1: begin
        mem_addr_cur = {wa1, 2'b00};
        mem_data_cur = st_hi;
        wren_cur     = we_q ? wren_hi : 4'h0;
        state_d      = RESP;
        rdata_d      = we_q ? 32'h0 : ld_data;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write enables are cut as soon as reset is asserted so an interrupted
  // split store never issues its second half.
  assign o_mem_wren  = i_reset ? wren_cur : 4'h0;
  assign o_mem_addr  = mem_addr_cur;
  assign o_mem_data  = mem_data_cur;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_err   = (state_q == RESP) && err_q;
  assign o_rsp_rdata = rdata_q;

  // State, captured request, fetched words and held memory drive.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      lo_q       <= 32'h0;
      hi_q       <= 32'h0;
      rdata_q    <= 32'h0;
      mem_addr_q <= '0;
      mem_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_cur;
      mem_data_q <= mem_data_cur;
      if (accept) begin
        we_q    <= i_req_we;
        uns_q   <= i_req_unsigned;
        size_q  <= i_req_size;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        err_q   <= req_bad;
      end
      if (state_q == ACC0) lo_q <= i_mem_q;
      if (state_q == ACC1) hi_q <= i_mem_q;
    end
  end

endmodule
